// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 matrix keypad scanner with column synchronisation and
//               press/release debounce, producing an inverted key code.
//               Optional key_stb acceptance pulse under KEYPAD_STROBE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV     = 50_000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] columnas,
    output logic [3:0] fila,
    output logic [3:0] Tecla,
    output logic       key_valid
`ifdef KEYPAD_STROBE_EN
    ,
    output logic       key_stb
`endif
);

    localparam int c_slot_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_cnt_w  = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [1:0] c_scan  = 2'd0;
    localparam logic [1:0] c_deb_p = 2'd1;
    localparam logic [1:0] c_held  = 2'd2;
    localparam logic [1:0] c_deb_r = 2'd3;

    logic [3:0]          r_col_meta, r_col_sync;
    logic [c_slot_w-1:0] r_slot;
    logic [1:0]          r_state, w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [3:0]          r_fila, w_fila_nxt;
    logic [3:0]          r_key, w_key_nxt;
    logic [3:0]          r_tecla, w_tecla_nxt;
    logic                r_valid, w_valid_nxt;
    logic                w_sample, w_hit, w_key_ok, w_same;
    logic [1:0]          w_row, w_col;
    logic [3:0]          w_key;
`ifdef KEYPAD_STROBE_EN
    logic                r_stb, w_stb_nxt;
`endif

    assign w_sample  = (r_slot == c_slot_w'(SCAN_DIV - 1));
    assign w_cnt_inc = r_cnt + c_cnt_w'(1);

    always_comb begin
        w_row = 2'd0;
        case (r_fila)
            4'b1101: w_row = 2'd1;
            4'b1011: w_row = 2'd2;
            4'b0111: w_row = 2'd3;
            default: w_row = 2'd0;
        endcase
    end

    // Lowest active column wins when several keys share the driven row.
    always_comb begin
        w_col = 2'd0;
        if (!r_col_sync[0])      w_col = 2'd0;
        else if (!r_col_sync[1]) w_col = 2'd1;
        else if (!r_col_sync[2]) w_col = 2'd2;
        else                     w_col = 2'd3;
    end

    assign w_hit    = (r_col_sync != 4'b1111);
    assign w_key    = {w_row, w_col};
    assign w_key_ok = w_hit && (w_key != 4'd15);
    assign w_same   = w_key_ok && (w_key == r_key);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fila_nxt  = r_fila;
        w_key_nxt   = r_key;
        w_tecla_nxt = r_tecla;
        w_valid_nxt = r_valid;
`ifdef KEYPAD_STROBE_EN
        w_stb_nxt   = 1'b0;
`endif
        if (w_sample) begin
            case (r_state)
                c_scan: begin
                    if (w_key_ok) begin
                        w_key_nxt   = w_key;
                        w_cnt_nxt   = c_cnt_w'(1);
                        w_state_nxt = c_deb_p;
                    end else begin
                        w_fila_nxt = {r_fila[2:0], r_fila[3]};
                    end
                end
                c_deb_p: begin
                    if (!w_same) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_scan;
                    end else if (w_cnt_inc == c_cnt_w'(DEBOUNCE_CNT)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_held;
                        w_tecla_nxt = ~(r_key + 4'd1);
                        w_valid_nxt = 1'b1;
`ifdef KEYPAD_STROBE_EN
                        w_stb_nxt   = 1'b1;
`endif
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                c_held: begin
                    if (!w_same) begin
                        w_cnt_nxt   = c_cnt_w'(1);
                        w_state_nxt = c_deb_r;
                    end
                end
                default: begin
                    // Release debounce: a returning key drops back to HELD without touching Tecla.
                    if (w_same) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_held;
                    end else if (w_cnt_inc == c_cnt_w'(DEBOUNCE_CNT)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_scan;
                        w_tecla_nxt = 4'b1111;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_meta <= 4'b1111;
            r_col_sync <= 4'b1111;
            r_slot     <= '0;
            r_state    <= c_scan;
            r_cnt      <= '0;
            r_fila     <= 4'b1110;
            r_key      <= '0;
            r_tecla    <= 4'b1111;
            r_valid    <= 1'b0;
        end else begin
            r_col_meta <= columnas;
            r_col_sync <= r_col_meta;
            r_slot     <= w_sample ? '0 : r_slot + c_slot_w'(1);
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_fila     <= w_fila_nxt;
            r_key      <= w_key_nxt;
            r_tecla    <= w_tecla_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

`ifdef KEYPAD_STROBE_EN
    always_ff @(posedge clk) begin
        if (rst) r_stb <= 1'b0;
        else     r_stb <= w_stb_nxt;
    end
    assign key_stb = r_stb;
`endif

    assign fila      = r_fila;
    assign Tecla     = r_tecla;
    assign key_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Directed self-checking bench for keypad_scanner using a
//               behavioural 4x4 keypad (SCAN_DIV=4, DEBOUNCE_CNT=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  columnas;
    logic [3:0]  fila;
    logic [3:0]  tecla;
    logic        key_valid;
    logic [15:0] press = '0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          stb_count = 0;
    int          stb_base;
    logic [3:0]  exp_fila;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV    (4),
        .DEBOUNCE_CNT(3)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .columnas (columnas),
        .fila     (fila),
        .Tecla    (tecla),
        .key_valid(key_valid)
`ifdef KEYPAD_STROBE_EN
        ,
        .key_stb  (key_stb)
`endif
    );

`ifdef KEYPAD_STROBE_EN
    logic key_stb;
    always @(posedge clk) if (key_stb) stb_count <= stb_count + 1;
`endif

    // Pressed keys pull their column low only while their row is driven.
    always_comb begin
        columnas = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!fila[r] && press[r*4+c]) columnas[c] = 1'b0;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One scan slot, ending on the falling edge just after the sampling edge.
    task automatic step(input int n);
        repeat (n) begin
            repeat (4) @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic align_row0();
        int k = 0;
        while (fila !== 4'b1110 && k < 16) begin
            step(1);
            k++;
        end
        check_eq("align_row0", fila, 4'b1110);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_fila", fila, 4'b1110);
        check_eq("rst_tecla", tecla, 4'b1111);
        check_eq("rst_valid", key_valid, 1'b0);
        rst = 1'b0;

        // Idle rotation
        exp_fila = 4'b1110;
        for (int i = 0; i < 10; i++) begin
            step(1);
            exp_fila = {exp_fila[2:0], exp_fila[3]};
            check_eq("idle_rotate", fila, exp_fila);
        end
        check_eq("idle_stb", stb_count, 0);

        // Key '1'
        align_row0();
        press[0] = 1'b1;
        step(2);
        check_eq("k1_early_valid", key_valid, 1'b0);
        step(1);
        check_eq("k1_tecla", tecla, 4'b1110);
        check_eq("k1_valid", key_valid, 1'b1);
        check_eq("k1_fila", fila, 4'b1110);
        step(2);
        check_eq("k1_frozen", fila, 4'b1110);
`ifdef KEYPAD_STROBE_EN
        check_eq("k1_stb", stb_count, 1);
`endif
        press = '0;
        step(3);
        check_eq("k1_rel_tecla", tecla, 4'b1111);
        check_eq("k1_rel_valid", key_valid, 1'b0);

        // Key 'A' and release
        align_row0();
        press[3] = 1'b1;
        step(3);
        check_eq("kA_tecla", tecla, 4'b1011);
        press = '0;
        step(2);
        check_eq("kA_rel_hold", tecla, 4'b1011);
        step(1);
        check_eq("kA_rel_tecla", tecla, 4'b1111);
        check_eq("kA_rel_valid", key_valid, 1'b0);
        step(1);
        check_eq("kA_resume", fila, 4'b1101);

        // Bounce on '2'
        align_row0();
        stb_base = stb_count;
        press[1] = 1'b1;
        step(2);
        press = '0;
        step(1);
        press[1] = 1'b1;
        step(2);
        check_eq("b2_not_yet", key_valid, 1'b0);
        step(1);
        check_eq("b2_tecla", tecla, 4'b1101);
        check_eq("b2_valid", key_valid, 1'b1);
        step(2);
`ifdef KEYPAD_STROBE_EN
        check_eq("b2_stb_once", stb_count - stb_base, 1);
`endif
        press = '0;
        step(4);

        // '2'+'3' together, then 'D' alone
        align_row0();
        press[1] = 1'b1;
        press[2] = 1'b1;
        step(3);
        check_eq("k23_tecla", tecla, 4'b1101);
        check_eq("k23_valid", key_valid, 1'b1);
        press = '0;
        step(4);
        check_eq("k23_rel", tecla, 4'b1111);
        press[15] = 1'b1;
        step(20);
        check_eq("kD_tecla", tecla, 4'b1111);
        check_eq("kD_valid", key_valid, 1'b0);
        press = '0;
        step(2);

        // '#' then mid-hold reset
        press[14] = 1'b1;
        for (int i = 0; i < 12 && key_valid !== 1'b1; i++) step(1);
        check_eq("kH_tecla", tecla, 4'b0000);
        stb_base = stb_count;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("kH_rst_tecla", tecla, 4'b1111);
        check_eq("kH_rst_valid", key_valid, 1'b0);
        check_eq("kH_rst_fila", fila, 4'b1110);
        rst = 1'b0;
        step(5);
        check_eq("kH_redet_early", key_valid, 1'b0);
        step(1);
        check_eq("kH_redet_tecla", tecla, 4'b0000);
        check_eq("kH_redet_valid", key_valid, 1'b1);
`ifdef KEYPAD_STROBE_EN
        check_eq("kH_stb", stb_count - stb_base, 1);
`endif
        press = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
